core_mem_ram: RTL and testbench

- AXI4-Lite responder that owns the accelerator-core scratch memory.
- Sits on the memory side of the user/accelerator arbitration mux and serves its single master port.
- Holds one inferred synchronous single-port RAM.
- Accepts write address and write data independently, arbitrates reads against writes round-robin, and returns OKAY or SLVERR responses.

---
 rtl/accel_core_pkg.sv | 14 +
 rtl/sp_ram_be.sv | 30 +++
 rtl/core_mem_ram.sv | 208 ++++++++++++++++++++
 tb/tb_core_mem_ram.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_core_pkg.sv
// Shared types and constants for the accelerator-core memory path.
package accel_core_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        RD_RESP
    } mem_fsm_t;

endpackage

// File: rtl/sp_ram_be.sv
// Single-port RAM with byte enables and a registered (1-cycle) read.
// Kept separate so it can be replaced by a vendor memory macro.
module sp_ram_be #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 4096,
    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic [DATA_WIDTH/8-1:0] we,
    input  logic [AW-1:0]           addr,
    input  logic [DATA_WIDTH-1:0]   din,
    output logic [DATA_WIDTH-1:0]   dout
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-masked write and synchronous read on the same enabled access.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int unsigned b = 0; b < DATA_WIDTH/8; b++) begin
                if (we[b]) begin
                    mem[addr][b*8 +: 8] <= din[b*8 +: 8];
                end
            end
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/core_mem_ram.sv
// AXI4-Lite responder for the accelerator-core scratch memory.
// Independent AW/W capture, round-robin read/write arbitration, one RAM port.
module core_mem_ram
    import accel_core_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 4096
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam int unsigned OFFS   = (NBYTES > 1) ? $clog2(NBYTES) : 0;
    localparam int unsigned IDXW   = ADDR_WIDTH - OFFS;
    localparam int unsigned RAW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    function automatic logic idx_ok(input logic [IDXW-1:0] idx);
        return 32'(idx) < DEPTH;
    endfunction

    mem_fsm_t              state_q, state_d;
    logic                  aw_full_q, aw_full_d, w_full_q, w_full_d;
    logic [IDXW-1:0]       aw_idx_q, aw_idx_d, ar_idx_q, ar_idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NBYTES-1:0]     wstrb_q, wstrb_d;
    logic                  last_wr_q, last_wr_d;
    logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
    logic                  rd_ok_q, rd_ok_d;
    logic                  awready_q, awready_d, wready_q, wready_d;
    logic                  arready_q, arready_d;

    logic                  aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic                  write_pending_d;
    logic                  aw_ok, ar_ok;
    logic                  ram_en;
    logic [NBYTES-1:0]     ram_we;
    logic [RAW-1:0]        ram_addr;
    logic [DATA_WIDTH-1:0] ram_dout;
    logic                  unused_addr_bits;

    assign aw_hs = awvalid && awready_q;
    assign w_hs  = wvalid  && wready_q;
    assign ar_hs = arvalid && arready_q;
    assign b_hs  = bvalid_q && bready;
    assign r_hs  = rvalid_q && rready;
    assign aw_ok = idx_ok(aw_idx_q);
    assign ar_ok = idx_ok(ar_idx_q);

    // Readys are registered from next-state so they are 0 straight out of reset.
    // arready is withheld while a write is pending and the write owns the next
    // turn, so a captured read always means the read has won arbitration.
    always_comb begin
        state_d   = state_q;
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        aw_idx_d  = aw_idx_q;
        ar_idx_d  = ar_idx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        last_wr_d = last_wr_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rd_ok_d   = rd_ok_q;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = awaddr[ADDR_WIDTH-1:OFFS];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            wdata_d  = wdata;
            wstrb_d  = wstrb;
        end
        if (b_hs) begin
            bvalid_d = 1'b0;
        end

        write_pending_d = aw_full_d && w_full_d && !bvalid_d;

        case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    ar_idx_d = araddr[ADDR_WIDTH-1:OFFS];
                    state_d  = RD;
                end else if (write_pending_d) begin
                    state_d = WR;
                end
            end
            WR: begin
                bresp_d   = aw_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                bvalid_d  = 1'b1;
                aw_full_d = 1'b0;
                w_full_d  = 1'b0;
                last_wr_d = 1'b1;
                state_d   = IDLE;
            end
            RD: begin
                rd_ok_d  = ar_ok;
                rresp_d  = ar_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                rvalid_d = 1'b1;
                state_d  = RD_RESP;
            end
            RD_RESP: begin
                if (r_hs) begin
                    rvalid_d  = 1'b0;
                    last_wr_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        write_pending_d = aw_full_d && w_full_d && !bvalid_d;
        awready_d = !aw_full_d;
        wready_d  = !w_full_d;
        arready_d = (state_d == IDLE) && !rvalid_d && !(write_pending_d && !last_wr_d);
    end

    // State, holding registers and response registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            aw_idx_q  <= '0;
            ar_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            last_wr_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rvalid_q  <= 1'b0;
            rresp_q   <= '0;
            rd_ok_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            aw_idx_q  <= aw_idx_d;
            ar_idx_q  <= ar_idx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            last_wr_q <= last_wr_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rd_ok_q   <= rd_ok_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
        end
    end

    assign ram_en   = ((state_q == WR) && aw_ok) || ((state_q == RD) && ar_ok);
    assign ram_we   = (state_q == WR) ? wstrb_q : '0;
    assign ram_addr = (state_q == WR) ? aw_idx_q[RAW-1:0] : ar_idx_q[RAW-1:0];

    sp_ram_be #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk  (aclk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (wdata_q),
        .dout (ram_dout)
    );

    assign awready = awready_q;
    assign wready  = wready_q;
    assign arready = arready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign rvalid  = rvalid_q;
    assign rresp   = rresp_q;
    assign rdata   = (rvalid_q && rd_ok_q) ? ram_dout : '0;

    // Byte-offset address bits carry no meaning for word accesses.
    assign unused_addr_bits = ^{awaddr, araddr};

endmodule

// File: tb/tb_core_mem_ram.sv
// Directed bench for core_mem_ram with a transaction-level memory model.
module tb_core_mem_ram;

    localparam int AWID  = 16;
    localparam int DWID  = 16;
    localparam int DEPTH = 4096;

    logic            aclk, aresetn;
    logic [AWID-1:0] awaddr, araddr;
    logic            awvalid, awready, wvalid, wready, bvalid, bready;
    logic            arvalid, arready, rvalid, rready;
    logic [DWID-1:0] wdata, rdata;
    logic [1:0]      wstrb, bresp, rresp;

    core_mem_ram #(
        .ADDR_WIDTH (AWID),
        .DATA_WIDTH (DWID),
        .DEPTH      (DEPTH)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
    endtask

    // ---------------- behavioural model ----------------
    // Memory of words; a write takes effect when its response appears and a
    // read sees the memory as of the moment its response appears.
    logic [15:0] mem_m [DEPTH];
    logic [15:0] aw_qu [$];
    logic [17:0] w_qu  [$];
    logic [15:0] ar_qu [$];
    int          log_q [$];   // 0 = write response, 1 = read response
    logic        b_act = 1'b0, r_act = 1'b0;
    logic [1:0]  exp_b = '0, exp_rr = '0;
    logic [15:0] exp_rd = '0;
    int          b_rises = 0, r_rises = 0;
    logic [15:0] m_a;
    logic [17:0] m_w;
    int          m_idx;

    initial forever begin
        @(negedge aclk);
        if (!aresetn) begin
            aw_qu.delete();
            w_qu.delete();
            ar_qu.delete();
            b_act = 1'b0;
            r_act = 1'b0;
            check("rst_bvalid", bvalid, 0);
            check("rst_rvalid", rvalid, 0);
            check("rst_rdata", rdata, 0);
            check("rst_readys", {awready, wready, arready}, 0);
        end else begin
            if (awvalid && awready) aw_qu.push_back(awaddr);
            if (wvalid && wready) w_qu.push_back({wstrb, wdata});
            if (arvalid && arready) ar_qu.push_back(araddr);

            if (bvalid) begin
                if (!b_act) begin
                    if (aw_qu.size() == 0 || w_qu.size() == 0) begin
                        timeout("b_without_aw_w");
                        exp_b = 2'b00;
                    end else begin
                        m_a   = aw_qu.pop_front();
                        m_w   = w_qu.pop_front();
                        m_idx = int'(m_a) / 2;
                        if (m_idx < DEPTH) begin
                            if (m_w[16]) mem_m[m_idx][7:0]  = m_w[7:0];
                            if (m_w[17]) mem_m[m_idx][15:8] = m_w[15:8];
                            exp_b = 2'b00;
                        end else begin
                            exp_b = 2'b10;
                        end
                    end
                    b_act = 1'b1;
                    b_rises++;
                    log_q.push_back(0);
                end
                check("bresp", bresp, exp_b);
                if (bready) b_act = 1'b0;
            end

            if (rvalid) begin
                if (!r_act) begin
                    if (ar_qu.size() == 0) begin
                        timeout("r_without_ar");
                        exp_rr = 2'b00;
                        exp_rd = '0;
                    end else begin
                        m_a   = ar_qu.pop_front();
                        m_idx = int'(m_a) / 2;
                        if (m_idx < DEPTH) begin
                            exp_rd = mem_m[m_idx];
                            exp_rr = 2'b00;
                        end else begin
                            exp_rd = '0;
                            exp_rr = 2'b10;
                        end
                    end
                    r_act = 1'b1;
                    r_rises++;
                    log_q.push_back(1);
                end
                check("rdata", rdata, exp_rd);
                check("rresp", rresp, exp_rr);
                if (rready) r_act = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_aw(input logic [15:0] a);
        logic done = 1'b0;
        awaddr = a; awvalid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge aclk);
            if (awready) done = 1'b1;
            @(posedge aclk); #1;
        end
        awvalid = 1'b0;
        if (!done) timeout("aw_handshake");
    endtask

    task automatic send_w(input logic [15:0] d, input logic [1:0] s);
        logic done = 1'b0;
        wdata = d; wstrb = s; wvalid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge aclk);
            if (wready) done = 1'b1;
            @(posedge aclk); #1;
        end
        wvalid = 1'b0;
        if (!done) timeout("w_handshake");
    endtask

    task automatic send_ar(input logic [15:0] a, output int hs);
        hs = -1;
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 200 && hs < 0; i++) begin
            @(negedge aclk);
            if (arready) hs = cyc;
            @(posedge aclk); #1;
        end
        arvalid = 1'b0;
        if (hs < 0) timeout("ar_handshake");
    endtask

    task automatic wait_b(output logic [1:0] resp, output int at);
        at = -1; resp = 2'b11;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            if (bvalid) begin at = cyc; resp = bresp; break; end
        end
        if (at < 0) timeout("wait_bvalid");
        else if (bready) begin @(posedge aclk); #1; end
    endtask

    task automatic wr_both(input logic [15:0] a, input logic [15:0] d, input logic [1:0] s,
                           output logic [1:0] resp, output int lat);
        int hs = -1;
        int at;
        resp = 2'b11; lat = -1;
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
        for (int i = 0; i < 200 && hs < 0; i++) begin
            @(negedge aclk);
            if (awready && wready) hs = cyc;
            @(posedge aclk); #1;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (hs < 0) begin timeout("aw_w_handshake"); return; end
        wait_b(resp, at);
        if (at >= 0) lat = at - hs;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d, output logic [1:0] r, output int lat);
        int hs;
        d = 16'hxxxx; r = 2'b11; lat = -1;
        send_ar(a, hs);
        if (hs < 0) return;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            if (rvalid) begin lat = cyc - hs; d = rdata; r = rresp; break; end
        end
        if (lat < 0) begin timeout("wait_rvalid"); return; end
        if (rready) begin @(posedge aclk); #1; end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [1:0]  resp, rr;
        logic [15:0] d;
        int          lat, hs, bb, rb, found;

        aresetn = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        araddr = '0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;

        repeat (3) @(negedge aclk);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        check("ready_at_release", {awready, wready, arready}, 3'b000);
        @(negedge aclk);
        check("ready_after_release", {awready, wready, arready}, 3'b111);
        @(posedge aclk); #1;

        // Write 0xBEEF to 0x0010 with AW and W together, then read back.
        wr_both(16'h0010, 16'hBEEF, 2'b11, resp, lat);
        check("wr1_bresp", resp, 2'b00);
        check("wr1_latency", lat, 2);
        rd(16'h0010, d, rr, lat);
        check("rd1_data", d, 16'hBEEF);
        check("rd1_rresp", rr, 2'b00);
        check("rd1_latency", lat, 2);

        // W three cycles ahead of AW, low byte only.
        send_w(16'h12AB, 2'b01);
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("wready_held", wready, 0);
            @(posedge aclk); #1;
        end
        send_aw(16'h0010);
        wait_b(resp, lat);
        check("wr2_bresp", resp, 2'b00);
        @(negedge aclk);
        check("wready_back", wready, 1);
        @(posedge aclk); #1;
        rd(16'h0010, d, rr, lat);
        check("rd2_strobe_merge", d, 16'hBEAB);

        // Out-of-range word 4096 against last word 4095.
        wr_both(16'h1FFE, 16'hCAFE, 2'b11, resp, lat);
        check("wr_last_bresp", resp, 2'b00);
        wr_both(16'h2000, 16'h5555, 2'b11, resp, lat);
        check("wr_oor_bresp", resp, 2'b10);
        rd(16'h2000, d, rr, lat);
        check("rd_oor_rresp", rr, 2'b10);
        check("rd_oor_data", d, 16'h0000);
        rd(16'h1FFE, d, rr, lat);
        check("rd_last_data", d, 16'hCAFE);

        // B back-pressure with a second write queued behind it.
        bready = 1'b0;
        bb = b_rises;
        fork
            send_aw(16'h0300);
            send_w(16'h1111, 2'b11);
        join
        wait_b(resp, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check("bvalid_hold", bvalid, 1);
            check("bresp_hold", bresp, 2'b00);
        end
        @(posedge aclk); #1;
        fork
            send_aw(16'h0302);
            send_w(16'h2222, 2'b11);
        join
        repeat (3) @(negedge aclk);
        check("second_b_blocked", b_rises - bb, 1);
        @(posedge aclk); #1;
        bready = 1'b1;
        for (int i = 0; i < 20 && b_rises - bb < 2; i++) @(negedge aclk);
        check("second_b_issued", b_rises - bb, 2);
        @(posedge aclk); #1;
        rd(16'h0300, d, rr, lat);
        check("rd_bp_first", d, 16'h1111);
        rd(16'h0302, d, rr, lat);
        check("rd_bp_second", d, 16'h2222);

        // Continuous reads against continuous writes must alternate.
        log_q.delete();
        bb = b_rises; rb = r_rises;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    fork
                        send_aw(16'h0200 + 16'(2 * i));
                        send_w(16'hA000 + 16'(i), 2'b11);
                    join
                end
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    int h;
                    send_ar((i % 2 == 1) ? 16'h1FFE : 16'h0010, h);
                end
            end
        join
        for (int i = 0; i < 50 && (b_rises - bb < 4 || r_rises - rb < 4); i++) @(negedge aclk);
        check("arb_count", log_q.size(), 8);
        for (int i = 1; i < log_q.size(); i++) begin
            check("arb_alternate", (log_q[i] == log_q[i-1]) ? 1 : 0, 0);
        end
        @(posedge aclk); #1;
        rd(16'h0206, d, rr, lat);
        check("rd_arb_last_write", d, 16'hA003);

        // Reset while a read response is stalled.
        wr_both(16'h0100, 16'h7777, 2'b11, resp, lat);
        rready = 1'b0;
        send_ar(16'h0100, hs);
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            @(negedge aclk);
            if (rvalid) found = 1;
        end
        check("rvalid_before_reset", found, 1);
        #2;
        aresetn = 1'b0;
        #1;
        check("rvalid_async_clear", rvalid, 0);
        check("readys_in_reset", {awready, wready, arready}, 3'b000);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        rready = 1'b1;
        @(negedge aclk);
        check("readys_after_rst", {awready, wready, arready, bvalid, rvalid}, 5'b00000);
        @(negedge aclk);
        check("arready_rises", arready, 1);
        @(posedge aclk); #1;
        rd(16'h0100, d, rr, lat);
        check("ram_kept_over_reset", d, 16'h7777);

        repeat (3) @(posedge aclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
